// File: rtl/fnd_pkg.sv
// Shared definitions for the FND digit scanner.
// The package holds:
//   - state_t    : scanner FSM states (IDLE, BLANK, SHOW)
//   - digit_on   : output level that lights a digit, keyed by ACTIVE_LOW
//   - digit_off  : output level that darkens a digit, keyed by ACTIVE_LOW
//   - DEF_*      : default timing (100 MHz clock, 1 ms slot, 20 us blank)
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_SLOT_CYCLES  = DEF_CLK_HZ / 1000;
  localparam int DEF_BLANK_CYCLES = 2000;

  function automatic logic digit_on(input bit active_low);
    return ~active_low;
  endfunction

  function automatic logic digit_off(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot counter for the FND digit scanner.
// Counts 0..SLOT_CYCLES-1 while run is high and wraps to 0 on its own.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous clear to 0 (wins over run)
//   run        : advance the counter this cycle
//   blank_done : count is on the last dark cycle of the slot
//   slot_done  : count is on the last cycle of the slot
module fnd_slot_timer
  import fnd_pkg::*;
#(
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0] count;

  assign blank_done = (count == CNT_W'(BLANK_CYCLES - 1));
  assign slot_done  = (count == CNT_W'(SLOT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= slot_done ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fnd_digit_scanner.sv
// Time-multiplexed digit enable controller for a multi-digit FND display.
// Each digit owns a slot of SLOT_CYCLES clocks; the first BLANK_CYCLES of
// every slot are dark so the upstream segment mux can switch data without
// ghosting. All outputs are registered.
// Ports:
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_en           : 1 = scan, 0 = all digits dark and scanner parked
//   i_digit_mask   : bit k = 1 keeps digit k dark during its slot
//   o_digit        : digit enables, at most one at the active level
//   o_digit_sel    : index of current/next digit for the segment mux
//   o_digit_strobe : one-cycle pulse on the first dark cycle of each slot
module fnd_digit_scanner
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_en,
  input  logic [NUM_DIGITS-1:0]         i_digit_mask,
  output logic [NUM_DIGITS-1:0]         o_digit,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_sel,
  output logic                          o_digit_strobe
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic LVL_ON  = digit_on(ACTIVE_LOW);
  localparam logic LVL_OFF = digit_off(ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{LVL_OFF}};

  state_t                  state;
  state_t                  state_next;
  logic [SEL_W-1:0]        sel_next;
  logic                    strobe_next;
  logic [NUM_DIGITS-1:0]   digit_next;
  logic                    tmr_clr;
  logic                    tmr_run;
  logic                    blank_done;
  logic                    slot_done;

  fnd_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (i_clk),
    .rst       (i_reset),
    .clr       (tmr_clr),
    .run       (tmr_run),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  always_comb begin
    state_next  = state;
    sel_next    = o_digit_sel;
    strobe_next = 1'b0;
    tmr_clr     = 1'b0;
    tmr_run     = (state != IDLE);
    digit_next  = ALL_OFF;

    // Disable outranks every transition, including the slot-end wrap.
    if (!i_en) begin
      state_next = IDLE;
      sel_next   = '0;
      tmr_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_next  = BLANK;
          sel_next    = '0;
          strobe_next = 1'b1;
          tmr_clr     = 1'b1;
        end
        BLANK: begin
          if (blank_done) state_next = SHOW;
        end
        SHOW: begin
          // The timer wraps itself to 0 on slot_done.
          if (slot_done) begin
            state_next  = BLANK;
            sel_next    = (o_digit_sel == SEL_W'(NUM_DIGITS - 1)) ?
                          '0 : o_digit_sel + SEL_W'(1);
            strobe_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          sel_next   = '0;
          tmr_clr    = 1'b1;
        end
      endcase
    end

    // Enables are computed from the next state so o_digit stays registered
    // and lines up with the state it belongs to.
    if (state_next == SHOW && !i_digit_mask[sel_next]) begin
      digit_next[sel_next] = LVL_ON;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      o_digit        <= ALL_OFF;
      o_digit_sel    <= '0;
      o_digit_strobe <= 1'b0;
    end else begin
      state          <= state_next;
      o_digit        <= digit_next;
      o_digit_sel    <= sel_next;
      o_digit_strobe <= strobe_next;
    end
  end

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Self-checking bench for fnd_digit_scanner with NUM_DIGITS=4,
// SLOT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
module tb_fnd_digit_scanner;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] digit;
  logic [1:0]   sel;
  logic         strobe;
  logic         prev_strobe = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fnd_digit_scanner #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_digit_mask  (mask),
    .o_digit       (digit),
    .o_digit_sel   (sel),
    .o_digit_strobe(strobe)
  );

  typedef struct {
    logic         en;
    logic [N-1:0] mask;
    logic [N-1:0] digit;
    logic [1:0]   sel;
    logic         strobe;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic e, input logic [N-1:0] m,
                      input logic [N-1:0] d, input logic [1:0] s,
                      input logic st);
    vec_t v;
    v.en = e; v.mask = m; v.digit = d; v.sel = s; v.strobe = st;
    vecs.push_back(v);
  endtask

  // One full slot: strobe on the first cycle, BLANK dark cycles, then pat.
  task automatic push_slot(input logic [1:0] s, input logic [N-1:0] m,
                           input logic [N-1:0] pat);
    for (int c = 0; c < SLOT; c++)
      push(1'b1, m, (c < BLANK) ? 4'b1111 : pat, s, (c == 0));
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (!$onehot0(~digit)) begin
        bad++;
        $display("FAIL onehot0: got digit=%b expected at most one low bit", digit);
      end
      if (strobe) begin
        total++;
        if (prev_strobe || digit != 4'b1111) begin
          bad++;
          $display("FAIL strobe_rule: got prev=%b digit=%b expected prev=0 digit=1111",
                   prev_strobe, digit);
        end
      end
    end
    prev_strobe <= strobe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    // Scan four slots, then wrap to digit 0.
    push_slot(2'd0, 4'b0000, 4'b1110);
    push_slot(2'd1, 4'b0000, 4'b1101);
    push_slot(2'd2, 4'b0000, 4'b1011);
    push_slot(2'd3, 4'b0000, 4'b0111);
    push_slot(2'd0, 4'b0000, 4'b1110);
    // Mask digit 2: its slot stays dark, timing and strobe unchanged.
    push_slot(2'd1, 4'b0000, 4'b1101);
    push_slot(2'd2, 4'b0100, 4'b1111);
    push_slot(2'd3, 4'b0100, 4'b0111);
    // Mask digit 0 mid-SHOW: dark from the edge that samples the new mask.
    for (int c = 0; c < SLOT; c++)
      push(1'b1, (c >= 5) ? 4'b0101 : 4'b0100,
           (c < BLANK || c >= 5) ? 4'b1111 : 4'b1110, 2'd0, (c == 0));
    push_slot(2'd1, 4'b0000, 4'b1101);
    // Drop enable during SHOW of digit 2, then re-enable.
    push(1'b1, 4'b0000, 4'b1111, 2'd2, 1'b1);
    push(1'b1, 4'b0000, 4'b1111, 2'd2, 1'b0);
    push(1'b1, 4'b0000, 4'b1011, 2'd2, 1'b0);
    push(1'b1, 4'b0000, 4'b1011, 2'd2, 1'b0);
    push(1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0);
    push(1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0);
    push(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b1);
    push(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
    push(1'b1, 4'b0000, 4'b1110, 2'd0, 1'b0);

    // Reset held.
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_strobe", 32'(strobe), 32'd0);
    #1 rst = 1'b0;

    // Released with enable low: parked.
    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("idle%0d_digit", i), 32'(digit), 32'hF);
      check($sformatf("idle%0d_sel", i), 32'(sel), 32'd0);
      check($sformatf("idle%0d_strobe", i), 32'(strobe), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      en   = vecs[i].en;
      mask = vecs[i].mask;
      step();
      check($sformatf("vec%0d_digit", i), 32'(digit), 32'(vecs[i].digit));
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_strobe", i), 32'(strobe), 32'(vecs[i].strobe));
    end

    // Enable dropped exactly on the slot-end cycle: IDLE wins, no strobe.
    en = 1'b1;
    for (int c = 3; c < SLOT; c++) begin
      step();
      check($sformatf("end_c%0d_digit", c), 32'(digit), 32'hE);
      check($sformatf("end_c%0d_sel", c), 32'(sel), 32'd0);
    end
    en = 1'b0;
    step();
    check("end_drop_digit", 32'(digit), 32'hF);
    check("end_drop_sel", 32'(sel), 32'd0);
    check("end_drop_strobe", 32'(strobe), 32'd0);
    step();
    check("end_idle_strobe", 32'(strobe), 32'd0);

    // Run into SHOW of digit 1, then assert reset between edges.
    en = 1'b1;
    repeat (SLOT + 5) step();
    check("pre_rst_digit", 32'(digit), 32'hD);
    check("pre_rst_sel", 32'(sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_digit", 32'(digit), 32'hF);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_strobe", 32'(strobe), 32'd0);
    step();
    check("held_rst_digit", 32'(digit), 32'hF);
    check("held_rst_strobe", 32'(strobe), 32'd0);
    #1 rst = 1'b0;
    step();
    check("restart_strobe", 32'(strobe), 32'd1);
    check("restart_sel", 32'(sel), 32'd0);
    check("restart_digit", 32'(digit), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_digit_scanner.md
Name: fnd_digit_scanner

Overview:
Parametrised time-multiplexing controller for a common-anode/cathode multi-digit FND (7-segment) display. It steps through NUM_DIGITS digit enables at a fixed slot rate and inserts an all-off dead time between digits to suppress ghosting. Per-digit masking and a global enable are supported. It exports the active digit index and a strobe so the segment-data mux/decoder upstream can switch data during dead time. It replaces fixed 4-digit, externally-sequenced digit decoding in the FND display path.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..16.
SLOT_CYCLES, 100000, clock cycles per digit slot, including dead time (1 ms at 100 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 2000, all-off cycles at the start of each slot; legal range 1..SLOT_CYCLES-1.
ACTIVE_LOW, 1, 1 = a digit is on when its o_digit bit is 0; 0 = on when 1.

Ports:
i_clk  input  1  system clock; all state updates on the rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_en  input  1  1 = scanning runs; 0 = all digits off, scanner parked.
i_digit_mask  input  NUM_DIGITS  bit k = 1 keeps digit k dark during its slot; slot timing is unchanged.
o_digit  output  NUM_DIGITS  digit enables, one-hot at active level during SHOW, otherwise all inactive.
o_digit_sel  output  $clog2(NUM_DIGITS)  index of current or next digit; drives the upstream segment mux.
o_digit_strobe  output  1  one-cycle pulse on the first cycle of each slot's BLANK phase.

Behaviour:
- Reset (async assert, sync release): state IDLE; slot counter 0; o_digit_sel=0; o_digit_strobe=0; o_digit all inactive (all 1s if ACTIVE_LOW, else all 0s).
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BLANK, SHOW.
- IDLE: o_digit inactive, sel=0. When i_en=1 is sampled: go to BLANK, sel=0, strobe=1, counter=0.
- BLANK: o_digit inactive. Counter increments each cycle. When counter == BLANK_CYCLES-1: go to SHOW.
- SHOW: o_digit bit[sel] active unless i_digit_mask[sel]=1, all other bits inactive. i_digit_mask is sampled every cycle, so a mask change takes effect on the next edge. When counter == SLOT_CYCLES-1: counter=0, sel=(sel==NUM_DIGITS-1)?0:sel+1, go to BLANK, strobe=1.
- Slot timing: each slot lasts exactly SLOT_CYCLES cycles, of which BLANK_CYCLES are dark. Full frame = NUM_DIGITS*SLOT_CYCLES cycles.
- i_en=0 sampled in any state: next edge goes to IDLE, o_digit inactive, sel=0, strobe=0, counter=0. Re-enabling always restarts at digit 0.
- i_en=0 has priority over the slot-end transition when both occur in the same cycle.
- o_digit_strobe is never high in two consecutive cycles. With BLANK_CYCLES>=1, o_digit is never active in the cycle the strobe is high.
- Counter width: $clog2(SLOT_CYCLES); no overflow, because the counter wraps explicitly.
- Mid-operation reset: outputs go to their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package fnd_pkg:
  - state enum (IDLE, BLANK, SHOW);
  - DIGIT_ON/DIGIT_OFF level helper function keyed by ACTIVE_LOW;
  - default timing constants (100 MHz clock, 1 ms slot).
- Sub-module fnd_slot_timer (parametrised counter): counts to SLOT_CYCLES-1, emits blank_done and slot_done pulses, and takes a sync clear. The FSM and output registers live in fnd_digit_scanner.

Test Plan:
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
1. Reset held, then released with i_en=0 -> o_digit=4'b1111, sel=0, strobe=0 for 50 cycles.
2. i_en=1, mask=0 -> first edge: strobe=1, sel=0, o_digit=1111 for 2 cycles, then 1110 for 6 cycles. Next slot: sel=1 with 1111x2, 1101x6. Sequence continues 1011, 0111, then wraps to sel=0 at cycle 32. Strobe count is 4 per 32 cycles.
3. mask=4'b0100 while running -> slot 2 shows 1111 for all 8 cycles, sel=2, strobe still pulses. Other digits are unchanged.
4. i_en dropped during SHOW of digit 2 -> next edge o_digit=1111, sel=0. Re-assert -> restart at digit 0 with a full BLANK.
5. i_en dropped on the exact slot-end cycle -> IDLE, sel=0, no strobe.
6. Async reset asserted mid-SHOW between clock edges -> o_digit=1111 and sel=0 before the next edge. Checker asserts one-hot-or-none on ~o_digit every cycle.
